// File: rtl/fp_pkg.sv
// Shared FP32 constants and result types for the add/sub and sibling FP pipelines.
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 24;
   localparam int FRAC_W = 23;

   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  fflags;
   } fp_res_t;

   localparam int FP_RES_W = $bits(fp_res_t);

endpackage

// File: rtl/add_p4_if.sv
// Stage-3 to stage-4 input stream and stage-4 to writeback output stream.
interface add_p4_if;
   import fp_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [EXP_W-1:0]  exp_large_out_s4;
   logic [7:0]        leading_zero_ctr;
   logic [MANT_W-1:0] left_shifted_mant;
   logic              sign_out_s4;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       result;
   logic [4:0]        fflags;

   modport master (
      output in_valid, exp_large_out_s4, leading_zero_ctr, left_shifted_mant, sign_out_s4,
      output out_ready,
      input  in_ready, out_valid, result, fflags
   );

   modport slave (
      input  in_valid, exp_large_out_s4, leading_zero_ctr, left_shifted_mant, sign_out_s4,
      input  out_ready,
      output in_ready, out_valid, result, fflags
   );

endinterface

// File: rtl/fp_skid_buf.sv
// Two-entry valid/ready skid buffer: output register O plus one skid register S.
// in_ready is registered and is simply the inverse of S occupancy.
module fp_skid_buf #(
   parameter int W = 37
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         o_valid_r;
   logic [W-1:0] o_data_r;
   logic         s_valid_r;
   logic [W-1:0] s_data_r;
   logic         in_ready_r;
   logic         in_fire_s;
   logic         out_fire_s;

   assign in_fire_s  = in_valid & in_ready_r;
   assign out_fire_s = o_valid_r & out_ready;

   // O/S occupancy: S only fills when O is held, and drains into O on the next transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid_r  <= 1'b0;
         o_data_r   <= {W{1'b0}};
         s_valid_r  <= 1'b0;
         s_data_r   <= {W{1'b0}};
         in_ready_r <= 1'b1;
      end else if (s_valid_r) begin
         if (out_fire_s) begin
            o_data_r   <= s_data_r;
            s_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
         end
      end else if (in_fire_s) begin
         if (!o_valid_r || out_ready) begin
            o_valid_r <= 1'b1;
            o_data_r  <= in_data;
         end else begin
            s_valid_r  <= 1'b1;
            s_data_r   <= in_data;
            in_ready_r <= 1'b0;
         end
      end else if (out_fire_s) begin
         o_valid_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = o_valid_r;
   assign out_data  = o_data_r;

endmodule

// File: rtl/add_p4.sv
// FP32 add/sub stage 4: exponent adjust, zero/special/underflow handling, packing,
// fflags generation, and hand-off through a skid buffer.
module add_p4
   import fp_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter bit KEEP_UF_SIGN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   add_p4_if.slave          bus,
   output logic [CNT_W-1:0] uf_count
);

   logic signed [EXP_W:0] e_s;
   logic                  zero_s;
   logic                  special_s;
   logic                  uf_s;
   logic                  in_fire_s;
   fp_res_t               res_s;
   fp_res_t               out_s;
   logic [CNT_W-1:0]      uf_count_r;

   assign e_s       = $signed({1'b0, bus.exp_large_out_s4}) - $signed({1'b0, bus.leading_zero_ctr});
   assign zero_s    = (bus.leading_zero_ctr >= 8'd24) || (bus.left_shifted_mant == 24'd0);
   assign special_s = (bus.exp_large_out_s4 == EXP_MAX);
   assign in_fire_s = bus.in_valid & bus.in_ready;

   // Result selection, priority zero > special > underflow > normal
   always_comb begin
      res_s  = '{result: 32'h0000_0000, fflags: 5'b00000};
      uf_s   = 1'b0;
      if (zero_s) begin
         res_s.result = 32'h0000_0000;
      end else if (special_s) begin
         if (bus.left_shifted_mant[FRAC_W-1:0] == 23'd0) begin
            res_s.result = {bus.sign_out_s4, EXP_MAX, 23'd0};
         end else begin
            res_s.result = QNAN;
         end
      end else if (e_s <= 9'sd0) begin
         uf_s                  = 1'b1;
         res_s.result          = {(KEEP_UF_SIGN ? bus.sign_out_s4 : 1'b0), 31'd0};
         res_s.fflags[FLAG_UF] = 1'b1;
         res_s.fflags[FLAG_NX] = 1'b1;
      end else begin
         res_s.result = {bus.sign_out_s4, e_s[EXP_W-1:0], bus.left_shifted_mant[FRAC_W-1:0]};
      end
   end

   // Underflow events count at input acceptance and stick at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         uf_count_r <= {CNT_W{1'b0}};
      end else if (in_fire_s && uf_s && (uf_count_r != {CNT_W{1'b1}})) begin
         uf_count_r <= uf_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign uf_count = uf_count_r;

   fp_skid_buf #(
      .W (FP_RES_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (res_s),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (out_s)
   );

   assign bus.result = out_s.result;
   assign bus.fflags = out_s.fflags;

endmodule

// File: tb/tb_add_p4.sv
// Scoreboard bench for add_p4: a default instance and a CNT_W=2 / KEEP_UF_SIGN=0
// instance share one stimulus stream; a monitor pops expected results on each transfer.
module tb_add_p4;
   import fp_pkg::*;

   typedef struct packed {
      logic [31:0] r1;
      logic [4:0]  f1;
      logic [31:0] r2;
      logic [4:0]  f2;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] uf1;
   logic [1:0]  uf2;

   add_p4_if if1 ();
   add_p4_if if2 ();

   assign if2.in_valid          = if1.in_valid;
   assign if2.exp_large_out_s4  = if1.exp_large_out_s4;
   assign if2.leading_zero_ctr  = if1.leading_zero_ctr;
   assign if2.left_shifted_mant = if1.left_shifted_mant;
   assign if2.sign_out_s4       = if1.sign_out_s4;
   assign if2.out_ready         = if1.out_ready;

   add_p4 #(.CNT_W(16), .KEEP_UF_SIGN(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave), .uf_count(uf1));
   add_p4 #(.CNT_W(2),  .KEEP_UF_SIGN(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave), .uf_count(uf2));

   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cnt1   = 0;
   int   cnt2   = 0;
   bit   mon_en = 1'b0;
   bit   done   = 1'b0;

   // Reference: {result, fflags} straight from the IEEE packing rules of this stage
   function automatic logic [36:0] ref_model(logic [7:0] ex, logic [7:0] lz, logic [23:0] m,
                                             logic s, bit keep);
      int e;
      if (lz >= 8'd24 || m == 24'd0) return 37'd0;
      if (ex == 8'd255) begin
         if (m[22:0] == 23'd0) return {s, 8'hFF, 23'd0, 5'd0};
         return {32'h7FC0_0000, 5'd0};
      end
      e = int'(ex) - int'(lz);
      if (e <= 0) return {(keep ? s : 1'b0), 31'd0, 5'b00011};
      return {s, 8'(e), m[22:0], 5'd0};
   endfunction

   task automatic check(string name, logic [63:0] got, logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic offer(logic [7:0] ex, logic [7:0] lz, logic [23:0] m, logic s);
      if1.in_valid          = 1'b1;
      if1.exp_large_out_s4  = ex;
      if1.leading_zero_ctr  = lz;
      if1.left_shifted_mant = m;
      if1.sign_out_s4       = s;
   endtask

   task automatic push_exp();
      logic [36:0] a;
      logic [36:0] b;
      a = ref_model(if1.exp_large_out_s4, if1.leading_zero_ctr, if1.left_shifted_mant, if1.sign_out_s4, 1'b1);
      b = ref_model(if1.exp_large_out_s4, if1.leading_zero_ctr, if1.left_shifted_mant, if1.sign_out_s4, 1'b0);
      sb.push_back({a, b});
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance
   task automatic send(logic [7:0] ex, logic [7:0] lz, logic [23:0] m, logic s);
      int waited = 0;
      offer(ex, lz, m, s);
      while (!if1.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!if1.in_ready) check("send_timeout", 64'd0, 64'd1);
      else push_exp();
      @(negedge clk);
      if1.in_valid = 1'b0;
   endtask

   // Monitor: counters every cycle, payload on every output transfer about to happen
   always @(negedge clk) begin
      #1;
      if (mon_en) begin
         exp_t e;
         logic [36:0] r;
         check("uf_count_16", 64'(uf1), 64'(cnt1));
         check("uf_count_2", 64'(uf2), 64'(cnt2));
         check("out_valid_pair", 64'(if2.out_valid), 64'(if1.out_valid));
         if (if1.out_valid && if1.out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 64'(if1.result), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("result_keep", 64'(if1.result), 64'(e.r1));
               check("fflags_keep", 64'(if1.fflags), 64'(e.f1));
               check("result_nokeep", 64'(if2.result), 64'(e.r2));
               check("fflags_nokeep", 64'(if2.fflags), 64'(e.f2));
            end
         end
         if (rst) begin
            cnt1 = 0;
            cnt2 = 0;
         end else if (if1.in_valid && if1.in_ready) begin
            r = ref_model(if1.exp_large_out_s4, if1.leading_zero_ctr, if1.left_shifted_mant, if1.sign_out_s4, 1'b1);
            if (r[1]) begin
               if (cnt1 < 65535) cnt1++;
               if (cnt2 < 3) cnt2++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      if1.out_ready = 1'b1;
      offer(8'd0, 8'd0, 24'd0, 1'b0);
      if1.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(if1.out_valid), 64'd0);
      check("rst_in_ready", 64'(if1.in_ready), 64'd1);
      check("rst_result", 64'(if1.result), 64'd0);
      check("rst_fflags", 64'(if1.fflags), 64'd0);
      check("rst_uf", 64'(uf1), 64'd0);
      mon_en = 1'b1;

      send(8'd127, 8'd0, 24'h800000, 1'b0);
      send(8'd130, 8'd3, 24'hC00000, 1'b1);
      send(8'd3,   8'd5, 24'h800000, 1'b1);
      repeat (2) @(negedge clk);
      check("uf_after_flush", 64'(uf1), 64'd1);

      send(8'd100, 8'd24, 24'h000000, 1'b1);
      send(8'd255, 8'd0,  24'h800000, 1'b0);
      send(8'd255, 8'd0,  24'h800000, 1'b1);
      send(8'd255, 8'd0,  24'hC00000, 1'b0);
      send(8'd90,  8'd30, 24'hA00000, 1'b0);
      send(8'd5,   8'd5,  24'h900000, 1'b1);
      send(8'd6,   8'd5,  24'h900000, 1'b1);

      repeat (5) send(8'd2, 8'd10, 24'h900000, 1'b1);
      repeat (2) @(negedge clk);
      check("uf_sat_2bit", 64'(uf2), 64'd3);

      // Backpressure: A and B accepted, C held until release, no bubbles after
      repeat (3) @(negedge clk);
      if1.out_ready = 1'b0;
      offer(8'd128, 8'd1, 24'h810000, 1'b0);
      check("bp_ready_a", 64'(if1.in_ready), 64'd1);
      push_exp();
      @(negedge clk);
      offer(8'd129, 8'd1, 24'h820000, 1'b1);
      check("bp_ready_b", 64'(if1.in_ready), 64'd1);
      push_exp();
      @(negedge clk);
      offer(8'd131, 8'd2, 24'h830000, 1'b0);
      check("bp_ready_c0", 64'(if1.in_ready), 64'd0);
      @(negedge clk);
      check("bp_ready_c1", 64'(if1.in_ready), 64'd0);
      if1.out_ready = 1'b1;
      check("bp_gap0", 64'(if1.out_valid), 64'd1);
      @(negedge clk);
      check("bp_ready_rel", 64'(if1.in_ready), 64'd1);
      check("bp_gap1", 64'(if1.out_valid), 64'd1);
      push_exp();
      @(negedge clk);
      if1.in_valid = 1'b0;
      check("bp_gap2", 64'(if1.out_valid), 64'd1);
      @(negedge clk);

      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [7:0]  ex;
               logic [7:0]  lz;
               logic [23:0] m;
               ex = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
               lz = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(24, 255)) : 8'($urandom_range(0, 23));
               m  = ($urandom_range(0, 9) == 0) ? 24'd0 : {1'b1, 23'($urandom)};
               send(ex, lz, m, 1'($urandom));
               if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               if1.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join

      if1.out_ready = 1'b1;
      for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
      check("drain_empty", 64'(sb.size()), 64'd0);

      // Reset with O and S both full; stalled results must vanish
      if1.out_ready = 1'b0;
      send(8'd1, 8'd4, 24'h800000, 1'b1);
      send(8'd2, 8'd9, 24'h800000, 1'b0);
      check("stall_ready", 64'(if1.in_ready), 64'd0);
      check("stall_valid", 64'(if1.out_valid), 64'd1);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", 64'(if1.out_valid), 64'd0);
      check("mid_rst_ready", 64'(if1.in_ready), 64'd1);
      check("mid_rst_uf", 64'(uf1), 64'd0);
      check("mid_rst_result", 64'(if1.result), 64'd0);
      if1.out_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("no_ghost", 64'(if1.out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
